led_bank_arbiter: RTL and testbench
===================================

# led_bank_arbiter

Round-robin arbiter and sequencer that shares the 6-bit board LED bank between several pattern requesters. When no requester owns the bank, the free-running blink pattern (counter MSBs from the blink logic) drives the LEDs. A requester that wins the bank has its pattern latched and displayed for a programmable number of clock cycles, then the bank is released. The block sits between the blink/status logic and the top-level `led` pins. It is the only driver of those pins.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `LED_WIDTH`, 6: LED bank width.
- `HOLD_BITS`, 24: width of the hold counter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  NUM_REQ  level request per requester.
- `pattern`  in  NUM_REQ*LED_WIDTH  requester i's pattern at bits [i*LED_WIDTH +: LED_WIDTH].
- `hold_cycles`  in  HOLD_BITS  display duration; shared, sampled at grant.
- `idle_pattern`  in  LED_WIDTH  pattern shown when the bank is unowned (blink counter MSBs).
- `led`  out  LED_WIDTH  registered LED drive.
- `grant`  out  NUM_REQ  one-hot owner; all-zero when unowned.
- `busy`  out  1  high when state is not IDLE.
- `done`  out  1  one-cycle pulse when a display period ends.

## Operation
States and transitions:
- **IDLE**
  - Each cycle: `led <= idle_pattern`.
  - If any `req` bit is high, select the winner by round robin and go to SHOW. On that edge:
    - `grant <= onehot(w)`
    - `led <= pattern[w]`
    - `cnt <= max(hold_cycles,1) - 1`
    - `last <= w`
- **SHOW**
  - `led` and `grant` hold their values.
  - If `cnt == 0`: go to RELEASE with `grant <= 0`, `done <= 1`, `led <= idle_pattern`.
  - Otherwise: `cnt <= cnt - 1`.
- **RELEASE**
  - `done <= 0`, `led <= idle_pattern`, go to IDLE.
  - `req` is not evaluated in this state.

Round robin:
- Search order is `last+1, last+2, …` modulo NUM_REQ.
- Reset sets `last = NUM_REQ-1`, so requester 0 has first priority after reset.

Sampling and changes during a display period:
- `pattern[w]` and `hold_cycles` are sampled only on the grant edge. Later changes have no effect on the current display period.
- Deasserting `req[w]` during SHOW does not shorten the display; the period always runs to completion.
- Requests from other requesters during SHOW or RELEASE are not queued. They are seen only if still high in IDLE.

Arithmetic and sizing:
- `hold_cycles = 0` is treated as 1.
- `cnt` is HOLD_BITS wide and never wraps, because it only decrements while non-zero.

Reset values (asynchronous, all outputs):
- `led = 0`, `grant = 0`, `busy = 0`, `done = 0`.
- State = IDLE, `cnt = 0`, `last = NUM_REQ-1`.

Reset mid-operation:
- Asserting `rst` during SHOW immediately clears `grant` and `led` and drops the display.
- No `done` pulse is produced.

## Timing
Latency:
- `req` is sampled high in IDLE at edge E0. `grant` and `led = pattern[w]` are valid from E0 until edge E_H, where H is the effective hold.
- The display therefore lasts exactly H cycles.

After the display:
- `done` is high for exactly 1 cycle, from E_H to E_{H+1}.
- `busy` is high from E0 to E_{H+1}.

Back-to-back grants:
- The earliest next grant edge is E_{H+2}.
- Consecutive displays are therefore separated by exactly 2 cycles of `idle_pattern`.

Output properties:
- `grant` is always one-hot or zero.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `led = 0`, `grant = 0`, `busy = 0`, `done = 0` immediately. After release with `idle_pattern = 6'b101010` and no `req`, `led = 6'b101010` one edge later.
- **Single request:** `req = 4'b0100`, `pattern[2] = 6'h2D`, `hold_cycles = 5` → `grant = 4'b0100` and `led = 6'h2D` for exactly 5 cycles, then `done` pulses once. `led` returns to `idle_pattern`, and `busy` is high for 6 cycles.
- **Fairness:** all `req` held at `4'b1111`, `hold_cycles = 1` → successive grants go to requesters 0, 1, 2, 3, 0. Each grant lasts 1 cycle with a 2-cycle gap between grants.
- **Zero hold:** `hold_cycles = 0` → display lasts 1 cycle, identical to `hold_cycles = 1`.
- **Sampling:** change `pattern[w]` and `hold_cycles` mid-SHOW and drop `req[w]` after 1 cycle → `led` holds the sampled pattern for the full originally sampled hold.
- **Reset during SHOW:** `hold_cycles = 100`, assert `rst` at cycle 40 → `grant = 0`, `led = 0`, and no `done` pulse. After release, a pending `req = 4'b1000` is granted to requester 3, because the pointer was reset.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin owner arbitration and timed display sequencing for the LED bank
module led_bank_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LED_WIDTH = 6,
  parameter int HOLD_BITS = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LED_WIDTH-1:0]   pattern,
  input  logic [HOLD_BITS-1:0]           hold_cycles,
  input  logic [LED_WIDTH-1:0]           idle_pattern,
  output logic [LED_WIDTH-1:0]           led,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state;
  logic [HOLD_BITS-1:0] cnt;
  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     cand;
  logic [LED_WIDTH-1:0] win_pattern;
  logic [HOLD_BITS-1:0] hold_load;

  // Round-robin pick: walk from the farthest candidate back to last+1 so the
  // nearest requesting index after the previous winner is the one that sticks.
  always_comb begin
    win  = last;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (req[cand]) begin
        win = cand;
      end
    end
  end

  // Winner's pattern slice and effective hold (a zero hold behaves like one cycle).
  always_comb begin
    win_pattern = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        win_pattern = pattern[i*LED_WIDTH +: LED_WIDTH];
      end
    end
    hold_load = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_BITS'(1);
  end

  // Sequencer: grant on any request in IDLE, hold for the sampled period,
  // then one RELEASE cycle (done pulse already issued) before re-arbitrating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= IDX_W'(NUM_REQ - 1);
      led   <= '0;
      grant <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= SHOW;
            grant <= NUM_REQ'(1) << win;
            led   <= win_pattern;
            cnt   <= hold_load;
            last  <= win;
            busy  <= 1'b1;
          end else begin
            led <= idle_pattern;
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            state <= RELEASE;
            grant <= '0;
            done  <= 1'b1;
            led   <= idle_pattern;
          end else begin
            cnt <= cnt - HOLD_BITS'(1);
          end
        end
        RELEASE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          led   <= idle_pattern;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
          led   <= idle_pattern;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - self-checking bench for led_bank_arbiter
module tb_led_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [23:0] pattern = '0;
  logic [23:0] hold_cycles = '0;
  logic [5:0]  idle_pattern = '0;
  logic [5:0]  led;
  logic [3:0]  grant;
  logic        busy;
  logic        done;

  led_bank_arbiter #(
    .NUM_REQ(4),
    .LED_WIDTH(6),
    .HOLD_BITS(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .pattern(pattern),
    .hold_cycles(hold_cycles),
    .idle_pattern(idle_pattern),
    .led(led),
    .grant(grant),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [5:0] led;
    int         len;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [23:0] pats;
    logic [23:0] hold;
    logic [3:0]  g;
    logic [5:0]  led;
    int          len;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_grants = 0;
  bit   chk_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [5:0] l, input int len);
    exp_t e;
    e.g = g;
    e.led = l;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || grant != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("timeout_idle", 0, 1);
  endtask

  task automatic wait_grant();
    int t;
    t = 0;
    @(negedge clk);
    while (grant == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("timeout_grant", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Scoreboard monitor: pops one expectation per grant and measures each period.
  initial begin : monitor
    exp_t       cur;
    logic [3:0] prev_grant;
    logic       prev_busy;
    bit         active;
    bit         have_prev;
    int         glen;
    int         brun;
    int         dcnt;
    int         gap;
    cur = '{g: 4'd0, led: 6'd0, len: 0};
    prev_grant = '0;
    prev_busy = 1'b0;
    active = 0;
    have_prev = 0;
    glen = 0;
    brun = 0;
    dcnt = 0;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_grant = '0;
        prev_busy = 1'b0;
        active = 0;
        have_prev = 0;
        glen = 0;
        brun = 0;
        dcnt = 0;
        gap = 0;
      end else begin
        if (grant != 0 && prev_grant == 0) begin
          if (chk_gap && have_prev) check("idle_gap", gap, 2);
          if (exp_q.size() == 0) begin
            check("unexpected_grant", grant, 0);
            cur = '{g: grant, led: led, len: 0};
          end else begin
            cur = exp_q.pop_front();
          end
          active = 1;
          glen = 0;
          n_grants++;
        end
        if (grant != 0) begin
          glen++;
          check("grant", grant, cur.g);
          check("led_show", led, cur.led);
        end else if (prev_grant != 0) begin
          check("hold_len", glen, cur.len);
          check("done_at_end", done, 1);
          check("led_idle_after", led, idle_pattern);
          gap = 1;
          have_prev = 1;
          active = 0;
        end else begin
          gap++;
        end
        if (busy) begin
          brun++;
          if (done) dcnt++;
        end else if (prev_busy) begin
          check("busy_len", brun, cur.len + 1);
          check("done_pulses", dcnt, 1);
          brun = 0;
          dcnt = 0;
        end
        prev_grant = grant;
        prev_busy = busy;
      end
    end
  end

  initial begin : stim
    vec_t vt[8];
    int   base;
    int   t;
    vt[0] = '{req: 4'b0100, pats: {6'h01, 6'h2D, 6'h02, 6'h03}, hold: 24'd5, g: 4'b0100, led: 6'h2D, len: 5};
    vt[1] = '{req: 4'b1111, pats: {6'h3F, 6'h11, 6'h22, 6'h33}, hold: 24'd2, g: 4'b1000, led: 6'h3F, len: 2};
    vt[2] = '{req: 4'b0110, pats: {6'h05, 6'h06, 6'h07, 6'h08}, hold: 24'd0, g: 4'b0010, led: 6'h07, len: 1};
    vt[3] = '{req: 4'b0001, pats: {6'h10, 6'h20, 6'h30, 6'h0F}, hold: 24'd3, g: 4'b0001, led: 6'h0F, len: 3};
    vt[4] = '{req: 4'b1001, pats: {6'h2A, 6'h15, 6'h0C, 6'h31}, hold: 24'd1, g: 4'b1000, led: 6'h2A, len: 1};
    vt[5] = '{req: 4'b1001, pats: {6'h2A, 6'h15, 6'h0C, 6'h31}, hold: 24'd4, g: 4'b0001, led: 6'h31, len: 4};
    vt[6] = '{req: 4'b0011, pats: {6'h00, 6'h00, 6'h1B, 6'h24}, hold: 24'd2, g: 4'b0010, led: 6'h1B, len: 2};
    vt[7] = '{req: 4'b0010, pats: {6'h3E, 6'h3D, 6'h3C, 6'h3B}, hold: 24'd1, g: 4'b0010, led: 6'h3C, len: 1};

    // Power-up reset, then asynchronous mid-cycle reset with idle LEDs lit.
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle_pattern = 6'h15;
    repeat (2) @(negedge clk);
    check("idle_led_pre", led, 6'h15);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_led", led, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    idle_pattern = 6'b101010;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_led_post", led, 6'b101010);

    // Table-driven single grants, pointer walks from reset value.
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      req = vt[i].req;
      pattern = vt[i].pats;
      hold_cycles = vt[i].hold;
      push_exp(vt[i].g, vt[i].led, vt[i].len);
      wait_grant();
      req = '0;
    end
    wait_idle();

    // Fairness with all requesters held and hold of one.
    do_reset();
    wait_idle();
    chk_gap = 1;
    pattern = {6'h3C, 6'h0F, 6'h33, 6'h2D};
    hold_cycles = 24'd1;
    push_exp(4'b0001, 6'h2D, 1);
    push_exp(4'b0010, 6'h33, 1);
    push_exp(4'b0100, 6'h0F, 1);
    push_exp(4'b1000, 6'h3C, 1);
    push_exp(4'b0001, 6'h2D, 1);
    base = n_grants;
    req = 4'b1111;
    t = 0;
    while (n_grants < base + 5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("timeout_fair", 0, 1);
    req = '0;
    wait_idle();
    chk_gap = 0;

    // Mid-display changes to pattern, hold and requests have no effect.
    req = 4'b0100;
    pattern = {6'h00, 6'h19, 6'h00, 6'h00};
    hold_cycles = 24'd6;
    push_exp(4'b0100, 6'h19, 6);
    wait_grant();
    req = 4'b0001;
    pattern = '1;
    hold_cycles = 24'd1;
    repeat (2) @(negedge clk);
    req = '0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("no_queued_grant", grant, 0);

    // Reset during a long display, then pointer restarts at requester 0.
    do_reset();
    wait_idle();
    req = 4'b0100;
    pattern = {6'h00, 6'h2B, 6'h00, 6'h00};
    hold_cycles = 24'd100;
    push_exp(4'b0100, 6'h2B, 100);
    wait_grant();
    req = '0;
    repeat (38) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("show_rst_grant", grant, 0);
    check("show_rst_led", led, 0);
    check("show_rst_busy", busy, 0);
    check("show_rst_done", done, 0);
    req = 4'b1010;
    pattern = {6'h00, 6'h00, 6'h1D, 6'h00};
    hold_cycles = 24'd2;
    push_exp(4'b0010, 6'h1D, 2);
    @(posedge clk);
    #1 check("show_rst_done_hold", done, 0);
    #1 rst = 1'b0;
    wait_grant();
    req = '0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
